// File: rtl/uart_mem_loader_pkg.sv
// Shared types and default timing constants for the UART program loader.
// Imported by the receiver sub-module and the loader top.
package uart_loader_pkg;

    localparam int DEF_CLKS_PER_BIT   = 434;        // 50 MHz / 115200 baud
    localparam int DEF_TIMEOUT_CYCLES = 5_000_000;
    localparam int DEF_ADDR_W         = 10;

    // ADDR_HI is folded into IDLE: the first header byte is latched there.
    typedef enum logic [2:0] {
        IDLE,
        ADDR_LO,
        CNT_HI,
        CNT_LO,
        DATA_HI,
        DATA_LO,
        WRITE,
        DONE
    } loader_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

endpackage

// File: rtl/uart_mem_loader_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, bit timer sampling at bit centres,
// LSB-first shift register, one-cycle byte_valid / frame_err pulses.
module uart_rx
    import uart_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       uart_rx_i,
    output logic [7:0] byte_o,
    output logic       byte_valid_o,
    output logic       frame_err_o
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

    rx_state_t        r_state, w_state_next;
    logic [1:0]       r_sync;
    logic             r_rx_prev;
    logic [CNT_W-1:0] r_cnt, w_cnt_next;
    logic [2:0]       r_bit, w_bit_next;
    logic [7:0]       r_shift, w_shift_next;
    logic             r_valid, w_valid_next;
    logic             r_ferr, w_ferr_next;
    logic             w_rx;

    assign w_rx = r_sync[1];

    // NOTE: every signal written here gets a default first, so no latch is inferred.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt + CNT_W'(1);
        w_bit_next   = r_bit;
        w_shift_next = r_shift;
        w_valid_next = 1'b0;
        w_ferr_next  = 1'b0;
        case (r_state)
            RX_IDLE: begin
                w_cnt_next = '0;
                if (r_rx_prev && !w_rx) w_state_next = RX_START;
            end
            RX_START: begin
                if (r_cnt == HALF_M1) begin
                    w_cnt_next   = '0;
                    w_bit_next   = '0;
                    w_state_next = w_rx ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (r_cnt == FULL_M1) begin
                    w_cnt_next   = '0;
                    w_shift_next = {w_rx, r_shift[7:1]};
                    w_bit_next   = r_bit + 3'd1;
                    if (r_bit == 3'd7) w_state_next = RX_STOP;
                end
            end
            RX_STOP: begin
                if (r_cnt == FULL_M1) begin
                    w_state_next = RX_IDLE;
                    w_valid_next = w_rx;
                    w_ferr_next  = !w_rx;
                end
            end
            default: w_state_next = RX_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= RX_IDLE;
            r_sync    <= 2'b11;   // idle-high line, so reset never fakes a start edge
            r_rx_prev <= 1'b1;
            r_cnt     <= '0;
            r_bit     <= '0;
            r_shift   <= '0;
            r_valid   <= 1'b0;
            r_ferr    <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_sync    <= {r_sync[0], uart_rx_i};
            r_rx_prev <= w_rx;
            r_cnt     <= w_cnt_next;
            r_bit     <= w_bit_next;
            r_shift   <= w_shift_next;
            r_valid   <= w_valid_next;
            r_ferr    <= w_ferr_next;
        end
    end

    assign byte_o       = r_shift;
    assign byte_valid_o = r_valid;
    assign frame_err_o  = r_ferr;

endmodule

// File: rtl/uart_mem_loader.sv
// Runtime program loader: parses ADDR/CNT/DATA frames from the UART and
// writes 16-bit words into the memory port, one ena/wren pulse per word.
module uart_mem_loader
    import uart_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT   = DEF_CLKS_PER_BIT,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int ADDR_W         = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              uart_rx_i,
    input  logic              enable_i,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [15:0]       mem_wdata_o,
    output logic              mem_ena_o,
    output logic              mem_wren_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic [15:0]       words_o
);

    localparam int GAP_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [7:0]        w_byte;
    logic              w_byte_valid, w_frame_err;
    loader_state_t     r_state, w_state_next;
    logic [7:0]        r_hi;
    logic [ADDR_W-1:0] r_addr;
    logic [15:0]       r_cnt, r_words, r_wdata;
    logic              r_err;
    logic [GAP_W-1:0]  r_gap;
    logic [15:0]       w_field;
    logic              w_waiting, w_timeout, w_abort;

    uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk          (clk),
        .reset        (reset),
        .uart_rx_i    (uart_rx_i),
        .byte_o       (w_byte),
        .byte_valid_o (w_byte_valid),
        .frame_err_o  (w_frame_err)
    );

    assign w_field   = {r_hi, w_byte};
    assign w_waiting = r_state inside {ADDR_LO, CNT_HI, CNT_LO, DATA_HI, DATA_LO};
    assign w_timeout = w_waiting && !w_byte_valid && (r_gap == GAP_W'(TIMEOUT_CYCLES - 1));
    assign w_abort   = (r_state != IDLE) && (w_frame_err || w_timeout);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_byte_valid && enable_i) w_state_next = ADDR_LO;
            ADDR_LO: if (w_byte_valid) w_state_next = CNT_HI;
            CNT_HI:  if (w_byte_valid) w_state_next = CNT_LO;
            CNT_LO:  if (w_byte_valid) w_state_next = (w_field == 16'd0) ? DONE : DATA_HI;
            DATA_HI: if (w_byte_valid) w_state_next = DATA_LO;
            DATA_LO: if (w_byte_valid) w_state_next = WRITE;
            WRITE:   w_state_next = (r_cnt == 16'd1) ? DONE : DATA_HI;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
        if (w_abort) w_state_next = IDLE;
    end

    always_ff @(posedge clk) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_state_next;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_hi    <= '0;
            r_addr  <= '0;
            r_cnt   <= '0;
            r_words <= '0;
            r_wdata <= '0;
            r_err   <= 1'b0;
            r_gap   <= '0;
        end else begin
            if (w_byte_valid) r_hi <= w_byte;   // upper half of whichever field is in flight
            case (r_state)
                IDLE: if (w_byte_valid && enable_i) begin
                    r_err   <= 1'b0;
                    r_words <= '0;
                end
                ADDR_LO: if (w_byte_valid) r_addr  <= w_field[ADDR_W-1:0];
                CNT_LO:  if (w_byte_valid) r_cnt   <= w_field;
                DATA_LO: if (w_byte_valid) r_wdata <= w_field;
                WRITE: begin
                    r_addr  <= r_addr + ADDR_W'(1);
                    r_words <= r_words + 16'd1;
                    r_cnt   <= r_cnt - 16'd1;
                end
                default: ;
            endcase
            if (w_abort) r_err <= 1'b1;
            if (w_waiting && !w_byte_valid) r_gap <= r_gap + GAP_W'(1);
            else                            r_gap <= '0;
        end
    end

    assign mem_addr_o  = r_addr;
    assign mem_wdata_o = r_wdata;
    assign mem_ena_o   = (r_state == WRITE);
    assign mem_wren_o  = (r_state == WRITE);
    assign busy_o      = (r_state != IDLE) && (r_state != DONE);
    assign done_o      = (r_state == DONE);
    assign err_o       = r_err;
    assign words_o     = r_words;

endmodule

// File: doc/uart_mem_loader.md
Name: uart_mem_loader

Overview:
- Upstream feeder for the SLC-3 memory subsystem.
- Receives a program image over a UART serial line and writes it word-by-word into the 1K x 16 memory through the memory's data/address/ena/wren port.
- Asserts busy so the top level can hold the CPU in reset and mux the loader onto the memory port while loading.
- Replaces the compile-time program image with a runtime load path.

Parameters:
CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200 baud); must be >= 4.
TIMEOUT_CYCLES, 5_000_000, maximum idle gap between bytes inside a frame before the frame is aborted.
ADDR_W, 10, memory address width.

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-low reset
uart_rx_i  input  1  asynchronous serial input, idle high, 8N1, LSB first
enable_i  input  1  loader armed; frames are accepted only while high
mem_addr_o  output  ADDR_W  memory word address
mem_wdata_o  output  16  memory write data
mem_ena_o  output  1  memory enable, one-cycle pulse per word
mem_wren_o  output  1  write enable, asserted together with mem_ena_o
busy_o  output  1  high from first header byte until DONE or abort
done_o  output  1  one-cycle pulse when a frame completes
err_o  output  1  sticky error; cleared on the next frame's first byte
words_o  output  16  words written in the current or last frame

Behaviour:
- Reset: the only reset is reset low at a clk edge (synchronous, active-low). All outputs go to 0, the FSM goes to IDLE, and the rx sampler returns to idle. Reset mid-frame discards the frame; memory already written is left as is.
- Rx path: uart_rx_i passes through a 2-flop synchronizer.
  - A falling edge starts the bit counter. The start bit is re-checked at CLKS_PER_BIT/2; if high, it is a glitch and the sampler returns to idle.
  - Data bits are sampled at bit centres.
  - Stop bit sampled 0: frame_err pulse, no byte_valid.
  - Stop bit sampled 1: byte_valid pulses for one cycle with the byte.
- Frame format is big-endian: ADDR_HI, ADDR_LO, CNT_HI, CNT_LO, then CNT words of DATA_HI, DATA_LO.
  - Address uses the low ADDR_W bits of the 16-bit field; the upper bits are ignored.
- FSM states:
  - IDLE: on byte_valid with enable_i=1, go to ADDR_LO. Latch the high byte, set busy_o, clear err_o and words_o.
  - ADDR_LO, CNT_HI, CNT_LO: each advances on byte_valid. If CNT=0 at the end of CNT_LO, go to DONE.
  - DATA_HI: advances to DATA_LO on byte_valid.
  - DATA_LO: on byte_valid, go to WRITE.
  - WRITE: exactly one cycle. mem_ena_o=mem_wren_o=1 with the current address and word. Then address+1 (wraps 1023->0, mod 2^ADDR_W), words_o+1, remaining count-1. Go to DATA_HI if words remain, else DONE.
  - DONE: done_o=1 for one cycle, busy_o drops in the same cycle, return to IDLE.
- Latency: the write strobe occurs 1 cycle after the DATA_LO byte_valid.
- Bytes arriving in IDLE with enable_i=0 are dropped silently.
- Abort: frame_err in any non-IDLE state, or the inter-byte gap counter reaching TIMEOUT_CYCLES, causes:
  - err_o=1, busy_o=0, no done_o pulse, return to IDLE;
  - partial writes are kept.
- enable_i falling mid-frame has no effect; the frame completes.
- Outside WRITE: mem_ena_o=mem_wren_o=0. mem_addr_o holds the next write address and mem_wdata_o holds the last word.
- Byte rate is far below the FSM rate; no byte can be lost during WRITE.

Decomposition:
- Package uart_loader_pkg holds:
  - the loader_state_t enum (IDLE, ADDR_HI, ADDR_LO, CNT_HI, CNT_LO, DATA_HI, DATA_LO, WRITE, DONE), with ADDR_HI folded into IDLE if unused;
  - default bit timing constants.
- Sub-module uart_rx contains the synchronizer, bit timer, and shift register. Outputs: byte_o[7:0], byte_valid_o, frame_err_o. Same clk/reset.
- The top-level memory-port mux and CPU reset hold belong to the parent, not this block.

Test Plan:
- Frame 00 10 00 02 | 12 34 | AB CD with enable_i=1 -> writes 0x1234@0x010 and 0xABCD@0x011, one ena/wren pulse each; done_o pulse; words_o=2; busy_o low afterwards.
- Address 0x03FF, count 2 -> writes at 0x3FF then 0x000 (wrap); upper address bits 0xFC00 ignored for address 0xFFFF.
- Count 0 (00 20 00 00) -> no memory strobe; done_o pulses right after CNT_LO; words_o=0.
- Stop bit forced 0 on the third data byte -> err_o=1, busy_o=0, no done_o, earlier word still written. Next valid frame clears err_o on its first byte.
- Line held idle for TIMEOUT_CYCLES after ADDR_LO (bench with TIMEOUT_CYCLES=2000) -> abort with err_o=1. Bytes sent with enable_i=0 -> no busy_o, no writes.
- reset low for one cycle mid DATA_LO -> all outputs 0, FSM IDLE. A following full frame loads correctly.
